// File: rtl/sync_updown.sv
// Free-running binary up/down counter, modulo 2^WIDTH, with an asynchronous
// active-low reset. The count register drives the output directly.

module sync_updown #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  output logic [WIDTH-1:0] counter
);

  // Natural WIDTH-bit overflow gives the wrap in both directions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter <= '0;
    end else if (up_down) begin
      counter <= counter + WIDTH'(1);
    end else begin
      counter <= counter - WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_sync_updown.sv
// Scoreboarded bench for sync_updown: a 4-bit and a 2-bit instance share one
// stimulus stream and are checked against modulo-arithmetic reference models.

module tb_sync_updown;

  logic       clk;
  logic       rst;
  logic       up_down;
  logic [3:0] count4;
  logic [1:0] count2;

  int checks = 0;
  int errors = 0;

  int model4 = 0;
  int model2 = 0;
  int expQ4[$];
  int expQ2[$];

  sync_updown #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .up_down(up_down),
    .counter(count4)
  );

  sync_updown #(.WIDTH(2)) dut2 (
    .clk    (clk),
    .rst    (rst),
    .up_down(up_down),
    .counter(count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock period of stimulus: drive inputs after the falling edge,
  // optionally glitch reset low between edges, then queue what the next
  // rising edge should produce.
  task automatic applyStimulus(input logic ud, input logic r, input logic pulse);
    @(negedge clk);
    up_down = ud;
    rst     = r;
    if (pulse) begin
      #1 rst = 1'b0;
      #1;
      checkOutput("async_reset_w4", {28'd0, count4}, 32'd0);
      checkOutput("async_reset_w2", {30'd0, count2}, 32'd0);
      model4 = 0;
      model2 = 0;
      #2 rst = r;
    end
    if (!r) begin
      model4 = 0;
      model2 = 0;
    end else if (ud) begin
      model4 = (model4 + 1) % 16;
      model2 = (model2 + 1) % 4;
    end else begin
      model4 = (model4 + 15) % 16;
      model2 = (model2 + 3) % 4;
    end
    expQ4.push_back(model4);
    expQ2.push_back(model2);
  endtask

  // Monitor: every rising edge that has a queued expectation is checked
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ4.size() > 0) checkOutput("count_w4", {28'd0, count4}, expQ4.pop_front());
      if (expQ2.size() > 0) checkOutput("count_w2", {30'd0, count2}, expQ2.pop_front());
    end
  end

  initial begin
    up_down = 1'b0;
    rst     = 1'b1;
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_init_w4", {28'd0, count4}, 32'd0);
    checkOutput("reset_init_w2", {30'd0, count2}, 32'd0);

    for (int i = 0; i < 5; i++) applyStimulus(i[0], 1'b0, 1'b0);

    // Down from 0 through the underflow and back to 0
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0);

    // Up through the overflow: 1..15, 0, 1
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 1'b0);

    // Up to 7, reverse to 4, then back up to 6
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0);

    // Up to 9, then a reset glitch between edges; next edge yields 1
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) != 0),
                    ($urandom_range(0, 19) == 0));
    end

    repeat (2) @(negedge clk);
    checkOutput("queue_drained_w4", expQ4.size(), 32'd0);
    checkOutput("queue_drained_w2", expQ2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_updown.md
Name: sync_updown

Overview:
- Synchronous binary up/down counter with a single direction-control input and a modulo-2^WIDTH wrap-around.
- General-purpose sequencing/count source, one clock domain.
- Counts on every rising clock edge while out of reset. There is no enable, so the count advances every cycle.
- Default build is a 4-bit counter with a 4-bit count output.

Parameters:
- WIDTH, 4, counter and output width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset; 0 = reset asserted, 1 = run.
- up_down  input  1  direction select; 1 = count up (+1), 0 = count down (-1).
- counter  output  WIDTH  current count value, driven directly from the state register.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset assertion: when rst=0, counter goes to 0 immediately, independent of clk, and holds at 0 while rst=0.
- Reset release: on rst 0->1 the counter holds 0 until the next rising clk edge. The first count update happens on the first rising edge where rst=1 is sampled.
  - Release coincident with a clock edge is treated as still in reset for that edge.
- Count rule, per rising edge with rst=1:
  - up_down=1: counter <= counter + 1.
  - up_down=0: counter <= counter - 1.
- Arithmetic: unsigned, modulo 2^WIDTH, no saturation and no overflow flag.
  - Up wrap: 2^WIDTH-1 -> 0 (15 -> 0 for WIDTH=4).
  - Down wrap: 0 -> 2^WIDTH-1 (0 -> 15 for WIDTH=4).
- Latency: one cycle. counter reflects the up_down value sampled at the preceding rising edge.
- Direction change: takes effect at the first rising edge where the new level is sampled. There is no pipeline and no dead cycle.
  - Example: value 5 counting down, up_down goes 0->1 before the edge -> next value 6.
- Reset mid-count: forces 0 asynchronously regardless of value or direction. Counting resumes from 0 after release per the release rule above.
- up_down is assumed synchronous to clk. No internal synchronizer.
- Output is registered (no combinational path from up_down to counter). Value is 0 at reset, never X after the first reset.
- State is exactly WIDTH flip-flops. No other internal state.

Test Plan:
- Reset hold: rst=0 for 5 clocks with up_down toggling -> counter stays 0 throughout. Asserting rst=0 between clock edges drops counter to 0 before the next edge.
- Down count with underflow: release rst with up_down=0 -> counter sequence 0,15,14,13,12 on successive edges. After 16 edges it is back to 0.
- Up count with overflow: up_down=1 from 0 -> 1,2,...,15,0,1. The wrap 15->0 occurs on the 16th edge.
- Direction reversal: count up to 7, set up_down=0 before the next edge -> 6,5,4. Set up_down=1 -> 5,6. Each change is applied exactly one edge later.
- Mid-operation reset: at counter=9 counting up, pulse rst=0 for 3 ns between edges -> counter=0 immediately. After release, the next edge gives 1.
- Parameter check: WIDTH=2, up_down=1 -> 0,1,2,3,0. WIDTH=2, up_down=0 -> 0,3,2,1,0.
